bp_stream_pump_out: RTL
=======================

# bp_stream_pump_out

Serializer between a BedRock memory-message producer FSM and the narrow stream bus.
- Accepts one header plus a sequence of `stream_data_width_p` data beats from the FSM.
- Emits them as bus beats, each carrying a latched header. The critical-word address is preserved on every beat, and beat indices wrap within the block.
- Sits directly upstream of the stream input pump. It drives that pump's `mem_header_i`, `mem_data_i`, `mem_v_i` and `mem_lock_i`.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: processor parameter set.
- `stream_data_width_p`, default `dword_width_p` (64): bus beat width in bits.
- `block_width_p`, default `cce_block_width_p` (512): block size; `stream_words_lp = block_width_p/stream_data_width_p`.
- `payload_mask_p`, default 0: bit `k` set means msg_type `k` carries data.
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `fsm_base_header_i`  in  `bp_bedrock_xce_mem_msg_header_width_lp`  message header; sampled only on the first beat.
- `fsm_data_i`  in  `stream_data_width_p`  beat data.
- `fsm_v_i`  in  1  beat valid.
- `fsm_ready_and_o`  out  1  beat accepted when `fsm_v_i & fsm_ready_and_o`.
- `fsm_cnt_o`  out  `data_len_width_lp`  index of the beat currently offered.
- `fsm_new_o`  out  1  first beat of a multi-beat message accepted this cycle.
- `fsm_done_o`  out  1  last (or only) beat of a message accepted this cycle.
- `mem_header_o`  out  header width  bus header.
- `mem_data_o`  out  `stream_data_width_p`  bus data.
- `mem_v_o`  out  1  bus valid.
- `mem_lock_o`  out  1  more beats of this message follow.
- `mem_ready_and_i`  in  1  bus ready.

## Operation
- **Derived values**, computed from `fsm_base_header_i` in `e_ready` and from the latched header in `e_stream`:
  - `num_stream = max((1<<size)/(stream_data_width_p/8), 1)`, truncated to `data_len_width_lp` bits. A full block yields 0, which is treated as `stream_words_lp`.
  - `has_data = payload_mask_p[msg_type]`.
  - `multi = has_data & (num_stream != 1)`.
  - `first_cnt = addr[stream_offset_width_lp +: data_len_width_lp]`.
- **States**:
  - `e_reset`: one cycle after reset; all outputs 0. Then goes to `e_ready`.
  - `e_ready`:
    - Forwards `fsm_base_header_i` and `fsm_data_i`; `fsm_cnt_o = first_cnt`.
    - On accept with `multi`: latch the header, load the counter with `first_cnt+1`, assert `fsm_new_o` and `mem_lock_o`, go to `e_stream`.
    - On accept with `~multi`: assert `fsm_done_o`, stay in `e_ready`, `mem_lock_o = 0`.
  - `e_stream`:
    - `mem_header_o` is the latched header, unchanged from beat 0, including the full critical address. `fsm_base_header_i` is ignored.
    - `fsm_cnt_o` is the counter value.
    - Each accept increments the counter modulo `stream_words_lp`, wrapping within the block.
    - `last_cnt = first_cnt + num_stream - 1`, modulo `stream_words_lp`.
    - Accept with `fsm_cnt_o == last_cnt`: `fsm_done_o = 1`, `mem_lock_o = 0`, go to `e_ready`.
    - Otherwise `mem_lock_o = 1`.
- `fsm_new_o` and `fsm_done_o` are never both high in one cycle.
- A message without payload (for example a read command) is always a single beat regardless of size. Its `mem_data_o` equals `fsm_data_i`.

## Timing
- Reset values: `fsm_ready_and_o`, `mem_v_o`, `mem_lock_o`, `fsm_new_o` and `fsm_done_o` are 0; `fsm_cnt_o` is 0. The state register enters `e_reset`.
- Reset asserted mid-stream: the message is abandoned, the counter and skid buffer are cleared, and no partial beats are emitted after reset.
- Without skid (default):
  - `mem_v_o = fsm_v_i` and `fsm_ready_and_o = mem_ready_and_i`, both purely combinational; zero-cycle latency.
  - Both are forced to 0 in `e_reset`.
- Handshakes:
  - The FSM must hold data and header stable while `fsm_v_i` is high and the beat is not accepted.
  - `mem_v_o` never depends on `mem_ready_and_i`.
- Back-to-back messages are supported: `fsm_done_o` and the next message's first beat can be accepted on consecutive cycles with no bubble.

## Configuration
- `BP_STREAM_PUMP_OUT_SKID_EN` defined:
  - A two-entry FIFO (`bsg_two_fifo`) registers `{mem_lock_o, mem_header_o, mem_data_o}` on the bus side.
  - `fsm_ready_and_o` is the FIFO's ready; `mem_v_o` is the FIFO's valid; bus latency is 1 cycle.
  - Full throughput is sustained when `mem_ready_and_i` is held at 1.
  - Counters and `fsm_new_o`/`fsm_done_o` advance on FSM-side accepts.
- Undefined: combinational pass-through as described under Timing.

## Test plan
- **Single beat, no payload:** uc_rd of size 8 B at addr 0x8000_0010 -> one bus beat, `mem_lock_o = 0`, `fsm_done_o` pulses on the accept cycle, `fsm_new_o = 0`.
- **Aligned full block:** wr of 64 B with addr offset 0 and data beats D0..D7 -> 8 bus beats; `fsm_cnt_o` runs 0..7; `mem_lock_o` is high on beats 0–6 and low on beat 7; the header addr is identical on all beats.
- **Critical-word wrap:** wr of 64 B at addr 0x...28 -> `fsm_cnt_o` sequence 5,6,7,0,1,2,3,4; done on cnt 4; every beat carries addr 0x...28.
- **Partial multi-beat:** 16 B write at offset 0x30 -> beats at cnt 6 and 7; done on 7.
- **Backpressure:** `mem_ready_and_i` toggles 1,0,0,1 mid-stream -> no beat lost or duplicated and `fsm_cnt_o` holds while stalled. With the skid macro defined, the bus trails the FSM by 1 cycle.
- **Reset mid-stream:** reset at beat 3 of 8 -> outputs are 0 the next cycle; the following single-beat message is emitted correctly.

Source files
------------

// File: rtl/bp_stream_pump_out.sv
// BedRock stream output pump: one header + N data beats from a producer FSM -> narrow stream bus beats.
// Optional build macro BP_STREAM_PUMP_OUT_SKID_EN inserts a 2-entry registered skid on the bus side.

package bp_stream_pump_out_pkg;
    localparam int dword_width_p     = 64;
    localparam int cce_block_width_p = 512;

    typedef enum int {e_bp_default_cfg = 0} bp_params_e;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef struct packed {
        logic [7:0]  payload;
        logic [39:0] addr;
        logic [2:0]  size;
        logic [3:0]  msg_type;
    } bp_bedrock_mem_header_s;

    localparam int bp_bedrock_xce_mem_msg_header_width_lp = $bits(bp_bedrock_mem_header_s);
endpackage

`ifdef BP_STREAM_PUMP_OUT_SKID_EN
// Two-entry valid/ready FIFO with registered outputs.
// Latency: 1 cycle from enqueue to v_o.
// Backpressure: ready_o drops only when both entries are occupied.
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);
    logic [width_p-1:0] mem_r [2];
    logic               head_r, tail_r;
    logic [1:0]         cnt_r;
    logic               enq, deq;

    assign ready_o = (cnt_r != 2'd2);
    assign v_o     = (cnt_r != 2'd0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem_r[head_r];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_r <= 1'b0;
            tail_r <= 1'b0;
            cnt_r  <= 2'd0;
        end else begin
            if (enq) tail_r <= ~tail_r;
            if (deq) head_r <= ~head_r;
            cnt_r <= cnt_r + {1'b0, enq} - {1'b0, deq};
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[tail_r] <= data_i;
    end
endmodule
`endif

// Serializes a header plus its data beats into bus beats that all carry the first beat's header.
// Latency: 0 cycles (combinational pass-through), 1 cycle with the skid FIFO.
// Backpressure: fsm_ready_and_o follows bus ready (or skid FIFO space); a stalled beat holds its count.
module bp_stream_pump_out
    import bp_stream_pump_out_pkg::*;
#(
    parameter bp_params_e  bp_params_p         = e_bp_default_cfg,
    parameter int          stream_data_width_p = dword_width_p,
    parameter int          block_width_p       = cce_block_width_p,
    parameter logic [15:0] payload_mask_p      = '0,
    localparam int hdr_width_lp           = bp_bedrock_xce_mem_msg_header_width_lp,
    localparam int stream_words_lp        = block_width_p / stream_data_width_p,
    localparam int data_len_width_lp      = $clog2(stream_words_lp),
    localparam int stream_offset_width_lp = $clog2(stream_data_width_p / 8)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [hdr_width_lp-1:0]        fsm_base_header_i,
    input  logic [stream_data_width_p-1:0] fsm_data_i,
    input  logic                           fsm_v_i,
    output logic                           fsm_ready_and_o,
    output logic [data_len_width_lp-1:0]   fsm_cnt_o,
    output logic                           fsm_new_o,
    output logic                           fsm_done_o,
    output logic [hdr_width_lp-1:0]        mem_header_o,
    output logic [stream_data_width_p-1:0] mem_data_o,
    output logic                           mem_v_o,
    output logic                           mem_lock_o,
    input  logic                           mem_ready_and_i
);
    if (bp_params_p != e_bp_default_cfg) begin : g_cfg_check
        $error("bp_stream_pump_out: only e_bp_default_cfg is supported");
    end

    typedef enum logic [1:0] {e_reset, e_ready, e_stream} state_e;

    state_e                         state_r, state_n;
    bp_bedrock_mem_header_s         hdr_r, hdr_cur;
    logic [data_len_width_lp-1:0]   cnt_r, first_cnt, num_stream, last_cnt;
    logic                           active, has_data, multi, accept, down_ready, lock;

    // A full block wraps the truncated beat count to 0; modular last_cnt math still lands right.
    function automatic logic [data_len_width_lp-1:0] calc_num_stream(input logic [2:0] size);
        int unsigned words;
        words = (32'd1 << size) / (stream_data_width_p / 8);
        if (words == 0) words = 1;
        return words[data_len_width_lp-1:0];
    endfunction

    assign active     = ~reset_i & (state_r != e_reset);
    assign hdr_cur    = (state_r == e_stream) ? hdr_r : bp_bedrock_mem_header_s'(fsm_base_header_i);
    assign first_cnt  = hdr_cur.addr[stream_offset_width_lp +: data_len_width_lp];
    assign num_stream = calc_num_stream(hdr_cur.size);
    assign has_data   = payload_mask_p[hdr_cur.msg_type];
    assign multi      = has_data & (num_stream != data_len_width_lp'(1));
    assign last_cnt   = first_cnt + num_stream - data_len_width_lp'(1);

    assign fsm_ready_and_o = active & down_ready;
    assign accept          = fsm_v_i & fsm_ready_and_o;

    always_comb begin
        state_n    = state_r;
        fsm_cnt_o  = '0;
        fsm_new_o  = 1'b0;
        fsm_done_o = 1'b0;
        lock       = 1'b0;
        case (state_r)
            e_reset: state_n = e_ready;
            e_ready: begin
                fsm_cnt_o = first_cnt;
                lock      = multi;
                if (accept) begin
                    if (multi) begin
                        fsm_new_o = 1'b1;
                        state_n   = e_stream;
                    end else begin
                        fsm_done_o = 1'b1;
                    end
                end
            end
            e_stream: begin
                fsm_cnt_o = cnt_r;
                lock      = (cnt_r != last_cnt);
                if (accept && (cnt_r == last_cnt)) begin
                    fsm_done_o = 1'b1;
                    state_n    = e_ready;
                end
            end
            default: state_n = e_reset;
        endcase
        if (reset_i) begin
            fsm_cnt_o = '0;
            lock      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_reset;
            cnt_r   <= '0;
            hdr_r   <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                if ((state_r == e_ready) && multi) begin
                    hdr_r <= hdr_cur;
                    cnt_r <= first_cnt + data_len_width_lp'(1);
                end else if (state_r == e_stream) begin
                    cnt_r <= cnt_r + data_len_width_lp'(1);
                end
            end
        end
    end

`ifdef BP_STREAM_PUMP_OUT_SKID_EN
    localparam int fifo_width_lp = 1 + hdr_width_lp + stream_data_width_p;

    logic [fifo_width_lp-1:0] fifo_dat;
    logic                     fifo_rdy;

    assign down_ready = fifo_rdy;

    bsg_two_fifo #(.width_p(fifo_width_lp)) skid (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  ({lock, hdr_cur, fsm_data_i}),
        .v_i     (accept),
        .ready_o (fifo_rdy),
        .data_o  (fifo_dat),
        .v_o     (mem_v_o),
        .yumi_i  (mem_v_o & mem_ready_and_i)
    );

    assign {mem_lock_o, mem_header_o, mem_data_o} = fifo_dat;
`else
    assign down_ready   = mem_ready_and_i;
    assign mem_v_o      = fsm_v_i & active;
    assign mem_lock_o   = lock;
    assign mem_header_o = active ? hdr_cur : '0;
    assign mem_data_o   = active ? fsm_data_i : '0;
`endif
endmodule
